// File: rtl/inst_rom_arbiter.sv
// rtl/inst_rom_arbiter.sv - two-port arbiter for the instruction ROM read port
//
// Shares one combinational ROM read port between the fetch unit (f) and a
// debug/readback unit (d). Fetch has fixed priority, a starvation counter
// bounds how long debug can be denied, and d_lock lets debug keep ownership
// across a multi-word burst. Read data is registered and returned one cycle
// after acceptance, together with an error flag.
//
// Ports:
//   clock, reset             rising-edge clock, asynchronous active-high reset
//   f_req, f_addr            fetch request and byte address
//   f_ready                  fetch accepted this cycle (combinational)
//   f_valid, f_data, f_err   fetch response (registered, one-cycle valid)
//   d_req, d_addr, d_lock    debug request, byte address, burst lock
//   d_ready                  debug accepted this cycle (combinational)
//   d_valid, d_data, d_err   debug response (registered, one-cycle valid)
//   rom_addr, rom_data       ROM read port (address out, data in)
//   locked                   arbiter is in the debug-locked state
module inst_rom_arbiter #(
  parameter int ADDR_WIDTH   = 5,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_ready,
  output logic        f_valid,
  output logic [31:0] f_data,
  output logic        f_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_lock,
  output logic        d_ready,
  output logic        d_valid,
  output logic [31:0] d_data,
  output logic        d_err,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        locked
);

  typedef enum logic {
    NORMAL = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state, state_next;
  logic [3:0]  wait_cnt, wait_next;
  logic        grant_f, grant_d;
  logic        sel_err;

  // Misaligned, or beyond the last ROM word.
  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (ADDR_WIDTH + 2)) != 32'd0);
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= NORMAL;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
    end
  end

  always_comb begin
    grant_f    = 1'b0;
    grant_d    = 1'b0;
    state_next = state;
    wait_next  = wait_cnt;
    if (!reset) begin
      case (state)
        NORMAL: begin
          grant_d = d_req && (!f_req || (wait_cnt == LIMIT));
          grant_f = f_req && !grant_d;
          if (grant_d && d_lock) begin
            state_next = LOCKED;
          end
          if (!d_req || grant_d) begin
            wait_next = 4'd0;
          end else if (wait_cnt < LIMIT) begin
            wait_next = wait_cnt + 4'd1;
          end
        end
        LOCKED: begin
          // Debug owns the port; releasing the lock takes effect at this edge,
          // so a debug grant here is the last word of the burst.
          grant_d = d_req;
          if (!d_lock) begin
            state_next = NORMAL;
          end
        end
        default: state_next = NORMAL;
      endcase
    end
  end

  assign f_ready  = grant_f;
  assign d_ready  = grant_d;
  assign rom_addr = grant_f ? f_addr : (grant_d ? d_addr : 32'd0);
  assign sel_err  = addr_err(rom_addr);
  assign locked   = (state == LOCKED);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      f_valid <= 1'b0;
      f_data  <= 32'd0;
      f_err   <= 1'b0;
      d_valid <= 1'b0;
      d_data  <= 32'd0;
      d_err   <= 1'b0;
    end else begin
      f_valid <= grant_f;
      d_valid <= grant_d;
      if (grant_f) begin
        f_data <= sel_err ? 32'd0 : rom_data;
        f_err  <= sel_err;
      end
      if (grant_d) begin
        d_data <= sel_err ? 32'd0 : rom_data;
        d_err  <= sel_err;
      end
    end
  end

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// tb/tb_inst_rom_arbiter.sv - scoreboard bench for inst_rom_arbiter
module tb_inst_rom_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        f_req, d_req, d_lock;
  logic [31:0] f_addr, d_addr;
  logic        f_ready, f_valid, f_err;
  logic        d_ready, d_valid, d_err;
  logic [31:0] f_data, d_data, rom_addr, rom_data;
  logic        locked;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t fq[$];
  resp_t dq[$];
  int    n_cmp  = 0;
  int    n_fail = 0;
  logic [31:0] mem [32];

  always #5 clock = ~clock;

  inst_rom_arbiter #(.ADDR_WIDTH(5), .STARVE_LIMIT(3)) dut (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ready(f_ready), .f_valid(f_valid),
    .f_data(f_data), .f_err(f_err),
    .d_req(d_req), .d_addr(d_addr), .d_lock(d_lock), .d_ready(d_ready),
    .d_valid(d_valid), .d_data(d_data), .d_err(d_err),
    .rom_addr(rom_addr), .rom_data(rom_data), .locked(locked)
  );

  assign rom_data = mem[rom_addr[6:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One arbitration cycle: drive, check the combinational grant, queue the
  // expected response of the winner, then advance past the clock edge.
  task automatic step(input logic fr, input logic [31:0] fa,
                      input logic dr, input logic [31:0] da, input logic dl,
                      input logic exp_f, input logic exp_d, input logic exp_lk,
                      input logic [31:0] exp_data, input logic exp_err);
    resp_t r;
    f_req = fr; f_addr = fa; d_req = dr; d_addr = da; d_lock = dl;
    #3;
    chk("f_ready", 32'(f_ready), 32'(exp_f));
    chk("d_ready", 32'(d_ready), 32'(exp_d));
    chk("rom_addr", rom_addr, exp_f ? fa : (exp_d ? da : 32'd0));
    chk("locked", 32'(locked), 32'(exp_lk));
    r.data = exp_data;
    r.err  = exp_err;
    if (exp_f) fq.push_back(r);
    if (exp_d) dq.push_back(r);
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin : monitor
    resp_t r;
    if (!reset) begin
      if (f_valid) begin
        if (fq.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL f_unexpected: got f_valid=1 data %h expected no response at %0t", f_data, $time);
        end else begin
          r = fq.pop_front();
          chk("f_data", f_data, r.data);
          chk("f_err", 32'(f_err), 32'(r.err));
        end
      end
      if (d_valid) begin
        if (dq.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL d_unexpected: got d_valid=1 data %h expected no response at %0t", d_data, $time);
        end else begin
          r = dq.pop_front();
          chk("d_data", d_data, r.data);
          chk("d_err", 32'(d_err), 32'(r.err));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[1] = 32'h2008_0005;

    // Reset holds everything at zero even with requests pending.
    reset = 1'b1; f_req = 1'b1; f_addr = 32'h8; d_req = 1'b1; d_addr = 32'h10; d_lock = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_f_ready", 32'(f_ready), 32'd0);
    chk("rst_d_ready", 32'(d_ready), 32'd0);
    chk("rst_rom_addr", rom_addr, 32'd0);
    chk("rst_f_valid", 32'(f_valid), 32'd0);
    chk("rst_d_valid", 32'(d_valid), 32'd0);
    chk("rst_f_data", f_data, 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    reset = 1'b0;

    // Single fetch, then idle so the lone valid pulse is observed.
    step(1, 32'h4, 0, 32'h0, 0,  1, 0, 0, 32'h2008_0005, 0);
    step(0, 32'h0, 0, 32'h0, 0,  0, 0, 0, 32'h0, 0);
    step(0, 32'h0, 0, 32'h0, 0,  0, 0, 0, 32'h0, 0);

    // Error and boundary addresses.
    step(1, 32'h6,  0, 32'h0,  0,  1, 0, 0, 32'h0, 1);
    step(0, 32'h0,  1, 32'h80, 0,  0, 1, 0, 32'h0, 1);
    step(0, 32'h0,  1, 32'h7C, 0,  0, 1, 0, 32'hA000_001F, 0);

    // Idle: nothing granted, starvation counter stays clear.
    step(0, 32'h0, 0, 32'h0, 0,  0, 0, 0, 32'h0, 0);
    step(0, 32'h0, 0, 32'h0, 0,  0, 0, 0, 32'h0, 0);
    chk("idle_wait_cnt", 32'(dut.wait_cnt), 32'd0);

    // Contention: fetch three times, debug on the fourth, repeating.
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++)
        step(1, 32'h10, 1, 32'h20, 0,  1, 0, 0, 32'hA000_0004, 0);
      step(1, 32'h10, 1, 32'h20, 0,  0, 1, 0, 32'hA000_0008, 0);
    end

    // Locked burst: debug wins after starving, holds for three words.
    for (int j = 0; j < 3; j++)
      step(1, 32'h10, 1, 32'h20, 1,  1, 0, 0, 32'hA000_0004, 0);
    step(1, 32'h10, 1, 32'h20, 1,  0, 1, 0, 32'hA000_0008, 0);
    step(1, 32'h10, 1, 32'h24, 1,  0, 1, 1, 32'hA000_0009, 0);
    step(1, 32'h10, 1, 32'h28, 0,  0, 1, 1, 32'hA000_000A, 0);
    step(1, 32'h10, 0, 32'h0,  0,  1, 0, 0, 32'hA000_0004, 0);
    step(0, 32'h0,  0, 32'h0,  0,  0, 0, 0, 32'h0, 0);

    // Reset during the response cycle discards the response.
    f_req = 1'b1; f_addr = 32'h8; d_req = 1'b0; d_lock = 1'b0;
    #3;
    chk("mid_f_ready", 32'(f_ready), 32'd1);
    @(posedge clock);
    #1;
    chk("mid_f_valid_pre", 32'(f_valid), 32'd1);
    f_req = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_f_valid", 32'(f_valid), 32'd0);
    chk("mid_f_data", f_data, 32'd0);
    chk("mid_f_err", 32'(f_err), 32'd0);
    chk("mid_d_valid", 32'(d_valid), 32'd0);
    chk("mid_rom_addr", rom_addr, 32'd0);
    chk("mid_locked", 32'(locked), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    step(0, 32'h0, 0, 32'h0, 0,  0, 0, 0, 32'h0, 0);
    step(0, 32'h0, 0, 32'h0, 0,  0, 0, 0, 32'h0, 0);

    chk("f_pending", 32'(fq.size()), 32'd0);
    chk("d_pending", 32'(dq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
